// File: rtl/mux_sel_ctrl_pkg.sv
// Shared encodings for the display mux select controller.
// FSM states and the mux select polarity.
package mux_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  localparam logic SEL_IN0 = 1'b1;
  localparam logic SEL_IN1 = 1'b0;

endpackage

// File: rtl/mux_sel_ctrl_key_debounce.sv
// Push-button synchroniser, stability filter and press pulse.
// press is a one-cycle registered pulse on a debounced 1->0 edge.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 26
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  logic             key_s1_q, key_s2_q;
  logic             key_db_q, key_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_db_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Accept the new level on the DB_CYCLES-th consecutive differing cycle.
  always_comb begin
    cnt_d    = '0;
    key_db_d = key_db_q;
    if (key_s2_q != key_db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        key_db_d = key_s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = key_db_q & ~key_db_d;
  end

  assign press = press_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// Select controller for the 7-bit 2:1 display mux.
// Round-robin arbitration with grant hold, or manual key toggle.
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       mode,
  input  logic       key_n,
  input  logic       req0,
  input  logic       req1,
  output logic       sel,
  output logic       grant0,
  output logic       grant1,
  output logic [1:0] state
);

  logic             mode_s1_q, mode_s2_q;
  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             hold_done;
  logic             press;
  logic             go0, go1;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_key (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .key_n    (key_n),
    .press    (press)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      state_q   <= ST_IDLE;
      sel_q     <= SEL_IN0;
      last_q    <= 1'b1;
      hold_q    <= '0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  assign hold_done = (hold_q == CNT_W'(HOLD_CYCLES));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    go0     = 1'b0;
    go1     = 1'b0;
    if (mode_s2_q) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      if (press) sel_d = ~sel_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req0 && (!req1 || last_q)) go0 = 1'b1;
          else if (req1)                 go1 = 1'b1;
        end
        ST_G0: begin
          if (!hold_done) hold_d = hold_q + CNT_W'(1);
          else if (req1)  go1 = 1'b1;
          else if (!req0) state_d = ST_IDLE;
        end
        ST_G1: begin
          if (!hold_done) hold_d = hold_q + CNT_W'(1);
          else if (req0)  go0 = 1'b1;
          else if (!req1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (go0) begin
        state_d = ST_G0;
        sel_d   = SEL_IN0;
        last_d  = 1'b0;
        hold_d  = '0;
      end
      if (go1) begin
        state_d = ST_G1;
        sel_d   = SEL_IN1;
        last_d  = 1'b1;
        hold_d  = '0;
      end
    end
  end

  assign sel    = sel_q;
  assign grant0 = (state_q == ST_G0);
  assign grant1 = (state_q == ST_G1);
  assign state  = state_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Scoreboard bench for mux_sel_ctrl against an ownership-level model.
// Small HOLD/DB values keep the scenarios short.
module tb_mux_sel_ctrl;

  localparam int HOLD = 4;
  localparam int DB   = 3;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       mode     = 1'b0;
  logic       key_n    = 1'b1;
  logic       req0     = 1'b0;
  logic       req1     = 1'b0;
  logic       sel, grant0, grant1;
  logic [1:0] state;

  mux_sel_ctrl #(
    .HOLD_CYCLES (HOLD),
    .DB_CYCLES   (DB),
    .CNT_W       (26)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .mode     (mode),
    .key_n    (key_n),
    .req0     (req0),
    .req1     (req1),
    .sel      (sel),
    .grant0   (grant0),
    .grant1   (grant1),
    .state    (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [4:0] q[$];
  int total = 0;
  int bad   = 0;

  // Model: who owns the mux, for how long, and the key/mode pipelines.
  bit m_ms1, m_ms2, m_ks1, m_ks2, m_deb, m_press, m_sel;
  int m_run, m_owner, m_held, m_last;

  function automatic void model_reset();
    m_ms1 = 0; m_ms2 = 0;
    m_ks1 = 1; m_ks2 = 1;
    m_deb = 1; m_run = 0; m_press = 0;
    m_owner = -1; m_held = 0; m_last = 1; m_sel = 1;
  endfunction

  function automatic void grant_to(int w);
    m_owner = w;
    m_held  = 0;
    m_last  = w;
    m_sel   = (w == 0);
  endfunction

  function automatic void model_step(bit md, bit kn, bit r0, bit r1);
    bit meff  = m_ms2;
    bit keff  = m_ks2;
    bit pnow  = m_press;
    bit pnext = 0;
    bit rq[2];
    rq[0] = r0;
    rq[1] = r1;
    if (keff != m_deb) begin
      m_run++;
      if (m_run == DB) begin
        pnext = m_deb && !keff;
        m_deb = keff;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (meff) begin
      m_owner = -1;
      m_held  = 0;
      if (pnow) m_sel = !m_sel;
    end else if (m_owner < 0) begin
      if (r0 && r1)  grant_to(m_last == 1 ? 0 : 1);
      else if (r0)   grant_to(0);
      else if (r1)   grant_to(1);
    end else if (m_held < HOLD) begin
      m_held++;
    end else if (rq[1-m_owner]) begin
      grant_to(1 - m_owner);
    end else if (!rq[m_owner]) begin
      m_owner = -1;
    end
    m_press = pnext;
    m_ms2 = m_ms1; m_ms1 = md;
    m_ks2 = m_ks1; m_ks1 = kn;
  endfunction

  function automatic logic [4:0] model_out();
    logic [1:0] st;
    st = (m_owner < 0) ? 2'd0 : 2'(m_owner + 1);
    return {m_sel, m_owner == 0, m_owner == 1, st};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act,
                     input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t {sel,g0,g1,st} got=%b want=%b",
               nm, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit md, input bit kn,
                       input bit r0, input bit r1);
    @(negedge CLOCK_50);
    mode = md; key_n = kn; req0 = r0; req1 = r1;
    @(posedge CLOCK_50);
    model_step(md, kn, r0, r1);
    q.push_back(model_out());
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("reset_async", {sel, grant0, grant1, state}, 5'b1_0_0_00);
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("reset_hold", {sel, grant0, grant1, state}, 5'b1_0_0_00);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    mode = 0; key_n = 1; req0 = 0; req1 = 0;
    @(posedge CLOCK_50);
    model_step(0, 1, 0, 0);
    q.push_back(model_out());
  endtask

  logic [4:0] mon_exp;
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (q.size() > 0) begin
        mon_exp = q.pop_front();
        chk("cycle", {sel, grant0, grant1, state}, mon_exp);
      end
    end
  end

  bit rm, rk;
  initial begin
    model_reset();
    do_reset();
    // contention from idle, then alternation
    repeat (20) cycle(0, 1, 1, 1);
    repeat (8)  cycle(0, 1, 0, 0);
    // short req1 then drop: hold keeps grant, then idle with sel=0
    cycle(0, 1, 0, 1);
    repeat (8) cycle(0, 1, 0, 0);
    // G0 hold done, then req0 drops while req1 rises
    repeat (7) cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 1);
    repeat (6) cycle(0, 1, 0, 0);
    // mode switch mid-grant, requests then ignored
    repeat (3) cycle(0, 1, 1, 0);
    repeat (4) cycle(1, 1, 1, 0);
    repeat (4) cycle(1, 1, 0, 1);
    // debounce: glitch, then a real press and release
    repeat (2) cycle(1, 0, 0, 0);
    repeat (8) cycle(1, 1, 0, 0);
    repeat (6) cycle(1, 0, 0, 0);
    repeat (10) cycle(1, 1, 0, 1);
    // back to arbitration from current sel
    repeat (8) cycle(0, 1, 1, 1);
    // reset mid-grant and mid-debounce
    do_reset();
    repeat (3) cycle(1, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    do_reset();
    // random traffic
    rm = 0; rk = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) rm = !rm;
      if ($urandom_range(0, 6) == 0)  rk = !rk;
      cycle(rm, rk, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0));
    end
    repeat (2) @(posedge CLOCK_50);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
